// File: rtl/edib_pkg.sv
// Shared constants, types and helpers for the EDIB status register bank.
package edib_pkg;

    // Widest data bus the constants below are sized for; users slice [DW-1:0].
    localparam int MAX_DW = 64;

    localparam logic [MAX_DW-1:0] ALL_ONES  = '1;
    localparam logic [MAX_DW-1:0] ALL_ZEROS = '0;

    // Pending flags always start at bit 0 of the status word.
    localparam int PEND_LSB = 0;

    // Which strobe transition an edge detector reports.
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_e;

    // Overflow field sits directly above the pending field.
    function automatic int ovf_lsb(input int nch);
        return PEND_LSB + nch;
    endfunction

    // Overflow field is only present when it cannot collide with rx_new.
    function automatic bit ovf_fits(input int nch, input int dw);
        return (2 * nch) <= (dw - 1);
    endfunction

    // rx_new always occupies the top bit of the status word.
    function automatic int rx_new_pos(input int dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/edib_edge_sync.sv
// Multi-flop synchroniser for an asynchronous strobe followed by a one-flop
// edge detector producing a single-cycle pulse on the selected transition.
module edib_edge_sync
    import edib_pkg::*;
#(
    parameter int    SYNC_STAGES = 2,
    parameter logic  RST_VAL     = 1'b0,
    parameter edge_e EDGE        = EDGE_FALL
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the strobe through the synchroniser; remember the last synced value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to the strobe's idle level so release never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign pulse = (EDGE == EDGE_FALL) ? (prev_q & ~sync_q[SYNC_STAGES-1])
                                       : (~prev_q & sync_q[SYNC_STAGES-1]);

endmodule

// File: rtl/edib_status_regbank.sv
// EDIB done-flag / receive register bank: per-channel pending and overflow
// flags, a receive capture register with new-data flag, an aggregate
// active-low interrupt and a registered, priority-selected DSP read buffer.
module edib_status_regbank
    import edib_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          dsp_clkout,
    input  logic          reset,
    input  logic [NCH-1:0] done_evt,
    input  logic [NCH-1:0] clr_req,
    input  logic [DW-1:0] rcvd_data,
    input  logic          rx_valid,
    input  logic          rx_hold,
    input  logic [NCH-1:0] sel_flag,
    input  logic          sel_rcv,
    input  logic          sel_stat,
    input  logic          rdh_wrl,
    output logic [DW-1:0] dsp_data_out,
    output logic          dsp_data_oe,
    output logic          irq_n
);

    logic [NCH-1:0] fall_pulse, rise_pulse;
    logic [NCH-1:0] pend_q, pend_d, ovf_q, ovf_d;
    logic [DW-1:0]  rcv_q, rcv_d, dbuf_q, dbuf_d, stat_word;
    logic           rx_new_q, rx_new_d, irq_n_q, irq_n_d;

    // Done strobes idle low (falling edge = done); clear strobes idle high.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        edib_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES),
            .RST_VAL    (1'b0),
            .EDGE       (EDGE_FALL)
        ) u_done_sync (
            .clk     (dsp_clkout),
            .reset   (reset),
            .async_in(done_evt[g]),
            .pulse   (fall_pulse[g])
        );
        edib_edge_sync #(
            .SYNC_STAGES(SYNC_STAGES),
            .RST_VAL    (1'b1),
            .EDGE       (EDGE_RISE)
        ) u_clr_sync (
            .clk     (dsp_clkout),
            .reset   (reset),
            .async_in(clr_req[g]),
            .pulse   (rise_pulse[g])
        );
    end

    // Flag update: a done event beats a coincident clear so no event is lost.
    always_comb begin
        pend_d  = (pend_q & ~rise_pulse) | fall_pulse;
        ovf_d   = (ovf_q & ~(rise_pulse & ~fall_pulse)) | (fall_pulse & pend_q);
        irq_n_d = ~|pend_q;
    end

    // Receive capture; a load coincident with a buffer capture keeps rx_new set.
    always_comb begin
        rcv_d    = rcv_q;
        rx_new_d = rx_new_q & ~sel_rcv;
        if (rx_valid && !rx_hold) begin
            rcv_d    = rcvd_data;
            rx_new_d = 1'b1;
        end
    end

    // Status word assembly: pend low, ovf above it when it fits, rx_new on top.
    always_comb begin
        stat_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (PEND_LSB + i < DW - 1) stat_word[PEND_LSB + i] = pend_q[i];
        end
        if (ovf_fits(NCH, DW)) begin
            for (int i = 0; i < NCH; i++) begin
                stat_word[ovf_lsb(NCH) + i] = ovf_q[i];
            end
        end
        stat_word[rx_new_pos(DW)] = rx_new_q;
    end

    // Read buffer source: receive > lowest selected flag word > status > hold.
    always_comb begin
        dbuf_d = dbuf_q;
        if (sel_rcv) begin
            dbuf_d = rcv_q;
        end else if (|sel_flag) begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (sel_flag[i]) dbuf_d = pend_q[i] ? ALL_ZEROS[DW-1:0] : ALL_ONES[DW-1:0];
            end
        end else if (sel_stat) begin
            dbuf_d = stat_word;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge dsp_clkout) begin
        if (reset) begin
            pend_q   <= '0;
            ovf_q    <= '0;
            rcv_q    <= '0;
            rx_new_q <= 1'b0;
            dbuf_q   <= '0;
            irq_n_q  <= 1'b1;
        end else begin
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            rcv_q    <= rcv_d;
            rx_new_q <= rx_new_d;
            dbuf_q   <= dbuf_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign dsp_data_out = dbuf_q;
    assign irq_n        = irq_n_q;
    assign dsp_data_oe  = rdh_wrl & (sel_rcv | (|sel_flag) | sel_stat);

endmodule
